// File: rtl/ti_and_sched_pkg.sv
// rtl/ti_and_sched_pkg.sv - shared state encoding and id-width helper for ti_and_sched
package ti_and_sched_pkg;

   localparam int MAX_NREQ = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EVAL  = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } sched_state_e;

   // Requester index width, never below one bit.
   function automatic int sched_id_w(input int nreq);
      return (nreq <= 2) ? 1 : $clog2(nreq);
   endfunction

endpackage

// File: rtl/ti_and_sched_rr.sv
// rtl/ti_and_sched_rr.sv - combinational round-robin arbiter, search starts after last_grant
module ti_and_sched_rr
   import ti_and_sched_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = sched_id_w(NREQ)
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [IDW-1:0]  last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx
);

   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(last_grant) + 1 + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/ti_and_sched.sv
// rtl/ti_and_sched.sv - round-robin scheduler around one registered 3-share TI AND
// Optional FLUSH state (share-register clearing) enabled by TI_AND_SCHED_FLUSH_EN.
module ti_and_sched
   import ti_and_sched_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NREQ-1:0]             req_valid,
   output logic [NREQ-1:0]             req_ready,
   input  logic [NREQ*W-1:0]           req_x0,
   input  logic [NREQ*W-1:0]           req_x1,
   input  logic [NREQ*W-1:0]           req_x2,
   input  logic [NREQ*W-1:0]           req_y0,
   input  logic [NREQ*W-1:0]           req_y1,
   input  logic [NREQ*W-1:0]           req_y2,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [sched_id_w(NREQ)-1:0] rsp_id,
   output logic [W-1:0]                rsp_q0,
   output logic [W-1:0]                rsp_q1,
   output logic [W-1:0]                rsp_q2,
   output logic                        busy
);

   localparam int IDW = sched_id_w(NREQ);

   sched_state_e   state_q, state_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] id_q, id_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic [W-1:0]   x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
   logic [W-1:0]   y0_q, y0_d, y1_q, y1_d, y2_q, y2_d;
   logic [W-1:0]   q0_q, q0_d, q1_q, q1_d, q2_q, q2_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           busy_q, busy_d;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_idx;
   logic [W-1:0]    ti_q0, ti_q1, ti_q2;

   ti_and_sched_rr #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req_valid  (req_valid),
      .last_grant (last_q),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   // Grant is only visible while idle and out of reset so nothing leaks during reset.
   assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;

   // Each output share omits exactly one input share index, which keeps the AND non-complete.
   assign ti_q0 = (x0_q & y0_q) ^ (x0_q & y1_q) ^ (x1_q & y0_q);
   assign ti_q1 = (x1_q & y1_q) ^ (x2_q & y1_q) ^ (x1_q & y2_q);
   assign ti_q2 = (x2_q & y2_q) ^ (x2_q & y0_q) ^ (x0_q & y2_q);

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      id_d        = id_q;
      rsp_id_d    = rsp_id_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      x2_d        = x2_q;
      y0_d        = y0_q;
      y1_d        = y1_q;
      y2_d        = y2_q;
      q0_d        = q0_q;
      q1_d        = q1_q;
      q2_d        = q2_q;
      rsp_valid_d = rsp_valid_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (|grant) begin
               for (int i = 0; i < NREQ; i++) begin
                  if (grant[i]) begin
                     x0_d = req_x0[i*W +: W];
                     x1_d = req_x1[i*W +: W];
                     x2_d = req_x2[i*W +: W];
                     y0_d = req_y0[i*W +: W];
                     y1_d = req_y1[i*W +: W];
                     y2_d = req_y2[i*W +: W];
                  end
               end
               id_d    = grant_idx;
               last_d  = grant_idx;
               state_d = EVAL;
               busy_d  = 1'b1;
            end
         end
         EVAL: begin
            q0_d        = ti_q0;
            q1_d        = ti_q1;
            q2_d        = ti_q2;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
`ifdef TI_AND_SCHED_FLUSH_EN
               state_d     = FLUSH;
`else
               state_d     = IDLE;
               busy_d      = 1'b0;
`endif
            end
         end
`ifdef TI_AND_SCHED_FLUSH_EN
         FLUSH: begin
            x0_d    = '0;
            x1_d    = '0;
            x2_d    = '0;
            y0_d    = '0;
            y1_d    = '0;
            y2_d    = '0;
            q0_d    = '0;
            q1_d    = '0;
            q2_d    = '0;
            state_d = IDLE;
            busy_d  = 1'b0;
         end
`endif
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= IDW'(NREQ - 1);
         id_q        <= '0;
         rsp_id_q    <= '0;
         x0_q        <= '0;
         x1_q        <= '0;
         x2_q        <= '0;
         y0_q        <= '0;
         y1_q        <= '0;
         y2_q        <= '0;
         q0_q        <= '0;
         q1_q        <= '0;
         q2_q        <= '0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         id_q        <= id_d;
         rsp_id_q    <= rsp_id_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         y0_q        <= y0_d;
         y1_q        <= y1_d;
         y2_q        <= y2_d;
         q0_q        <= q0_d;
         q1_q        <= q1_d;
         q2_q        <= q2_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_q0    = q0_q;
   assign rsp_q1    = q1_q;
   assign rsp_q2    = q2_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ti_and_sched.sv
// tb/tb_ti_and_sched.sv - directed vector table plus multi-cycle sequences for ti_and_sched
module tb_ti_and_sched;

   localparam int NREQ = 2;
   localparam int W    = 8;
`ifdef TI_AND_SCHED_FLUSH_EN
   localparam int PERIOD = 4;
`else
   localparam int PERIOD = 3;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_x0 = '0, req_x1 = '0, req_x2 = '0;
   logic [NREQ*W-1:0] req_y0 = '0, req_y1 = '0, req_y2 = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [0:0]        rsp_id;
   logic [W-1:0]      rsp_q0, rsp_q1, rsp_q2;
   logic              busy;

   int vec_n  = 0;
   int miss_n = 0;
   int model_last = NREQ - 1;

   ti_and_sched #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x0    (req_x0),
      .req_x1    (req_x1),
      .req_x2    (req_x2),
      .req_y0    (req_y0),
      .req_y1    (req_y1),
      .req_y2    (req_y2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_q0    (rsp_q0),
      .rsp_q1    (rsp_q1),
      .rsp_q2    (rsp_q2),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          r;
      logic [47:0] sh;   // {x0,x1,x2,y0,y1,y2}
      logic [7:0]  exp_q;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_n++;
      if (act !== exp) begin
         miss_n++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_shares(input int r, input logic [47:0] sh);
      req_x0[r*W +: W] = sh[47:40];
      req_x1[r*W +: W] = sh[39:32];
      req_x2[r*W +: W] = sh[31:24];
      req_y0[r*W +: W] = sh[23:16];
      req_y1[r*W +: W] = sh[15:8];
      req_y2[r*W +: W] = sh[7:0];
   endtask

   // Issue one request and stop at the negedge of the first HOLD cycle.
   task automatic do_op(input int r, input logic [47:0] sh, input logic [7:0] exp_q);
      int n;
      @(posedge clk); #1;
      drive_shares(r, sh);
      req_valid = '0;
      req_valid[r] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready[r] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         chk("grant_timeout", 32'(n), 32'd0);
         req_valid = '0;
         return;
      end
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("eval_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("rsp_valid_t2", 32'(rsp_valid), 32'd1);
      chk("rsp_xor", 32'(rsp_q0 ^ rsp_q1 ^ rsp_q2), 32'(exp_q));
      chk("rsp_id", 32'(rsp_id), 32'(r));
      model_last = r;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [47:0] sh;
      logic [7:0]  x, y, cq0, cq1, cq2;
      logic [0:0]  cid;
      int r, g, gid, exp_g, last_cyc, cyc;

      vecs[0] = '{0, 48'h13_5C_EA_77_0F_44, 8'h24};
      vecs[1] = '{1, 48'hFF_00_00_0F_F0_00, 8'hFF};
      vecs[2] = '{0, 48'h00_00_00_AA_55_FF, 8'h00};
      vecs[3] = '{1, 48'h11_22_44_0F_0F_35, 8'h35};
      vecs[4] = '{0, 48'hAA_AA_AA_F0_0F_F0, 8'h0A};
      vecs[5] = '{1, 48'hC3_3C_00_5A_5A_5A, 8'h5A};

      // Reset state
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_q", 32'({rsp_q0, rsp_q1, rsp_q2}), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors
      for (int i = 0; i < 6; i++) begin
         do_op(vecs[i].r, vecs[i].sh, vecs[i].exp_q);
      end
      @(negedge clk);
      wait_idle();

      // Simultaneous requests: strict alternation at the nominal period
      @(posedge clk); #1;
      drive_shares(0, 48'h13_5C_EA_77_0F_44);
      drive_shares(1, 48'hC3_3C_00_5A_5A_5A);
      req_valid = '1;
      g = 0;
      exp_g = (model_last + 1) % NREQ;
      last_cyc = 0;
      cyc = 0;
      while (g < 4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (|req_ready) begin
            chk("rr_onehot", 32'($countones(req_ready)), 32'd1);
            gid = req_ready[1] ? 1 : 0;
            chk("rr_order", 32'(gid), 32'(exp_g));
            if (g > 0) chk("rr_period", 32'(cyc - last_cyc), 32'(PERIOD));
            exp_g = (gid + 1) % NREQ;
            model_last = gid;
            last_cyc = cyc;
            g++;
         end
      end
      chk("rr_grant_count", 32'(g), 32'd4);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      wait_idle();

      // Backpressure in HOLD
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      drive_shares(1, 48'h11_22_44_0F_0F_35);
      req_valid = 2'b10;
      r = 0;
      @(negedge clk);
      while (!rsp_valid && r < 20) begin
         if (req_ready[1]) begin
            @(posedge clk); #1;
            req_valid = '0;
         end
         @(negedge clk);
         r++;
      end
      chk("bp_reach_hold", 32'(rsp_valid), 32'd1);
      cq0 = rsp_q0; cq1 = rsp_q1; cq2 = rsp_q2; cid = rsp_id;
      chk("bp_xor", 32'(cq0 ^ cq1 ^ cq2), 32'h35);
      req_valid = '1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_stable", 32'({rsp_q0, rsp_q1, rsp_q2, rsp_id}), 32'({cq0, cq1, cq2, cid}));
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_done", 32'(rsp_valid), 32'd0);
`ifdef TI_AND_SCHED_FLUSH_EN
      chk("flush_busy", 32'(busy), 32'd1);
      chk("flush_out", 32'({rsp_q0, rsp_q1, rsp_q2}), 32'd0);
      chk("flush_in", 32'(dut.x0_q | dut.x1_q | dut.x2_q | dut.y0_q | dut.y1_q | dut.y2_q), 32'd0);
`else
      chk("retain_out", 32'({rsp_q0, rsp_q1, rsp_q2, rsp_id}), 32'({cq0, cq1, cq2, cid}));
      chk("bp_busy", 32'(busy), 32'd0);
`endif
      model_last = 1;
      wait_idle();

      // Random regression
      for (int i = 0; i < 1000; i++) begin
         sh = {$urandom, $urandom_range(65535, 0)};
         x = sh[47:40] ^ sh[39:32] ^ sh[31:24];
         y = sh[23:16] ^ sh[15:8] ^ sh[7:0];
         do_op($urandom_range(NREQ - 1, 0), sh, x & y);
      end
      @(negedge clk);
      wait_idle();

      // Reset during EVAL
      @(posedge clk); #1;
      drive_shares(1, 48'hFF_00_00_0F_F0_00);
      req_valid = 2'b10;
      r = 0;
      @(negedge clk);
      while (!req_ready[1] && r < 20) begin
         @(negedge clk);
         r++;
      end
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs", 32'({req_ready, rsp_valid, busy, rsp_id}), 32'd0);
      chk("mid_rst_q", 32'({rsp_q0, rsp_q1, rsp_q2}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
      end
      req_valid = '1;
      #1;
      chk("post_rst_prio", 32'(req_ready), 32'b01);
      req_valid = '0;
      model_last = NREQ - 1;
      do_op(0, 48'h13_5C_EA_77_0F_44, 8'h24);
      @(negedge clk);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
      $finish;
   end

endmodule
